// File: rtl/mips_wb_pkg.sv
// rtl/mips_wb_pkg.sv - shared widths and requester indices for the writeback arbiter
// Purpose: register-file geometry and fixed writeback requester numbering.
// Ports: none (package).
package mips_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Fixed requester slots on the writeback port.
    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Purpose: picks the first asserted request after ptr, wrapping modulo N.
// Ports:
//   req     in  N      request vector
//   en      in  1      0 forces no grant
//   ptr     in  IDX_W  index of the last winner
//   gnt     out N      one-hot grant (or zero)
//   gnt_idx out IDX_W  index of the granted requester
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Search starts one past the last winner so it ends up lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && en && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write port arbiter with pending-write scoreboard
// Purpose: round-robin shares the single reg-file write port between writeback
//   requesters, registers the winning write, and tracks outstanding writes per register.
// Ports:
//   clk, reset(active-low sync), flush, wb_enable
//   req_valid/req_ready/req_addr/req_data   requester handshake, packed per requester
//   rsv_valid/rsv_addr                      destination reservation from decode
//   addr_a/addr_b -> hazard_a/hazard_b      stale-operand lookup for decode
//   write/write_addr/data_in                registered reg-file write port
//   sb_err                                  sticky reservation overflow
module reg_wb_arbiter
    import mips_wb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wb_enable,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic                     rsv_valid,
    input  logic [REG_ADDR_W-1:0]    rsv_addr,
    input  logic [REG_ADDR_W-1:0]    addr_a,
    input  logic [REG_ADDR_W-1:0]    addr_b,
    output logic                     hazard_a,
    output logic                     hazard_b,
    output logic                     write,
    output logic [REG_ADDR_W-1:0]    write_addr,
    output logic [DATA_W-1:0]        data_in,
    output logic                     sb_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]      ptr_q;
    logic                  write_q;
    logic [REG_ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  sb_err_q, sb_err_d;
    logic [PEND_W-1:0]     cnt_q [NUM_REGS];
    logic [PEND_W-1:0]     cnt_d [NUM_REGS];

    logic [N_REQ-1:0]      gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  inc, dec;

    // Reset low also blocks grants so nothing is accepted while held in reset.
    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req     (req_valid),
        .en      (wb_enable && !flush && reset),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(gnt & req_valid);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scoreboard next state; r0 never counts, reserve and retire on the same
    // register cancel, saturation holds the count and raises the sticky error.
    always_comb begin
        sb_err_d = sb_err_q;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            inc = rsv_valid && (rsv_addr == REG_ADDR_W'(r)) && (r != 0);
            dec = write_q && (write_addr_q == REG_ADDR_W'(r)) && (r != 0);
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_q      <= 1'b0;
            write_addr_q <= '0;
            data_q       <= '0;
            ptr_q        <= IDX_W'(N_REQ - 1);
            sb_err_q     <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
            // Flush gates the arbiter, so accept is already low on a flush cycle.
            if (accept) begin
                write_q      <= (sel_addr != '0);
                write_addr_q <= sel_addr;
                data_q       <= sel_data;
                ptr_q        <= gnt_idx;
            end else begin
                write_q <= 1'b0;
            end
        end
    end

    assign hazard_a   = (addr_a != '0) && (cnt_q[addr_a] != '0);
    assign hazard_b   = (addr_b != '0) && (cnt_q[addr_b] != '0);
    assign write      = write_q;
    assign write_addr = write_addr_q;
    assign data_in    = data_q;
    assign sb_err     = sb_err_q;

endmodule
